// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding, default timing parameters and sizing helper for the
// PLL start-up / lock-supervision controller.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PWRUP  = 3'd1,
    ST_KICK   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_MEAS   = 3'd4,
    ST_LOCKED = 3'd5,
    ST_FAULT  = 3'd6
  } pll_st_e;

  localparam int PWRUP_CYC_D  = 8;
  localparam int KICK_CYC_D   = 16;
  localparam int SETTLE_CYC_D = 1024;
  localparam int WIN_LOG2_D   = 6;
  localparam int TOL_D        = 1;
  localparam int MAX_RETRY_D  = 3;

  // Width of a down-the-line phase timer that must reach the largest of three counts.
  function automatic int tmr_bits(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_ctrl_lockdet.sv
// Feedback synchroniser, rising-edge detector, window timer and frequency
// comparator; flags the last cycle of each window and whether it was in tolerance.
module pll_ctrl_lockdet
  import pll_ctrl_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_D,
  parameter int TOL      = TOL_D
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_fb,
  output logic o_win_done,
  output logic o_win_good
);

  localparam int NOM = 1 << (WIN_LOG2 - 2);

  logic [2:0]          r_sync;
  logic [WIN_LOG2-1:0] r_tmr;
  logic [WIN_LOG2-1:0] r_cnt;
  logic                w_edge;
  logic                w_last;
  logic [WIN_LOG2-1:0] w_cnt_nxt;
  int                  w_err;

  assign w_edge = r_sync[1] & ~r_sync[2];
  assign w_last = i_run && (r_tmr == '1);

  // Saturating count including an edge seen on the window's final cycle.
  assign w_cnt_nxt = (w_edge && (r_cnt != '1)) ? r_cnt + WIN_LOG2'(1) : r_cnt;

  always_comb begin
    w_err = int'(w_cnt_nxt) - NOM;
    if (w_err < 0) w_err = -w_err;
  end

  assign o_win_done = w_last;
  assign o_win_good = w_last && (w_err <= TOL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_tmr  <= '0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_fb};
      if (!i_run) begin
        r_tmr <= '0;
        r_cnt <= '0;
      end else begin
        r_tmr <= r_tmr + WIN_LOG2'(1);
        r_cnt <= w_last ? '0 : w_cnt_nxt;
      end
    end
  end

endmodule

// File: rtl/pll_ctrl.sv
// PLL power-up sequencer: power-up, loop kick, settle, then continuous
// frequency-window lock supervision with retry/fault and relock handling.
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int PWRUP_CYC  = PWRUP_CYC_D,
  parameter int KICK_CYC   = KICK_CYC_D,
  parameter int SETTLE_CYC = SETTLE_CYC_D,
  parameter int WIN_LOG2   = WIN_LOG2_D,
  parameter int TOL        = TOL_D,
  parameter int MAX_RETRY  = MAX_RETRY_D
) (
  input  logic       CK_REF,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       FB_DIV4,
  output logic       PWRUP_1V8,
  output logic       KICK,
  output logic       LOCKED,
  output logic       FAULT,
  output logic [2:0] STATE
);

  localparam int TW = tmr_bits(PWRUP_CYC, KICK_CYC, SETTLE_CYC);
  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY);

  pll_st_e       r_st;
  logic [TW-1:0] r_tmr;
  logic [RW-1:0] r_retry;
  logic          r_bad;
  logic          r_arm;
  logic          r_pwr;
  logic          r_kick;
  logic          r_lock;
  logic          r_fault;
  logic          w_run;
  logic          w_done;
  logic          w_good;

  assign PWRUP_1V8 = r_pwr;
  assign KICK      = r_kick;
  assign LOCKED    = r_lock;
  assign FAULT     = r_fault;
  assign STATE     = r_st;

  // Gated by EN so the window counters clear on the same edge the FSM drops to OFF.
  assign w_run = EN && ((r_st == ST_MEAS) || (r_st == ST_LOCKED));

  pll_ctrl_lockdet #(
    .WIN_LOG2 (WIN_LOG2),
    .TOL      (TOL)
  ) u_lockdet (
    .i_clk      (CK_REF),
    .i_rst_n    (RST_N),
    .i_run      (w_run),
    .i_fb       (FB_DIV4),
    .o_win_done (w_done),
    .o_win_good (w_good)
  );

  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      r_st    <= ST_OFF;
      r_tmr   <= '0;
      r_retry <= '0;
      r_bad   <= 1'b0;
      r_arm   <= 1'b0;
      r_pwr   <= 1'b0;
      r_kick  <= 1'b0;
      r_lock  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_arm <= 1'b1;
      if (!EN) begin
        r_st    <= ST_OFF;
        r_tmr   <= '0;
        r_retry <= '0;
        r_bad   <= 1'b0;
        r_pwr   <= 1'b0;
        r_kick  <= 1'b0;
        r_lock  <= 1'b0;
        r_fault <= 1'b0;
      end else if (r_arm) begin
        // r_arm holds off the first transition until one edge after reset release.
        case (r_st)
          ST_OFF: begin
            r_st  <= ST_PWRUP;
            r_tmr <= '0;
            r_pwr <= 1'b1;
          end
          ST_PWRUP: begin
            if (r_tmr == TW'(PWRUP_CYC - 1)) begin
              r_st   <= ST_KICK;
              r_tmr  <= '0;
              r_kick <= 1'b1;
            end else begin
              r_tmr <= r_tmr + TW'(1);
            end
          end
          ST_KICK: begin
            if (r_tmr == TW'(KICK_CYC - 1)) begin
              r_st   <= ST_SETTLE;
              r_tmr  <= '0;
              r_kick <= 1'b0;
            end else begin
              r_tmr <= r_tmr + TW'(1);
            end
          end
          ST_SETTLE: begin
            if (r_tmr == TW'(SETTLE_CYC - 1)) begin
              r_st  <= ST_MEAS;
              r_tmr <= '0;
            end else begin
              r_tmr <= r_tmr + TW'(1);
            end
          end
          ST_MEAS: begin
            if (w_done) begin
              if (w_good) begin
                r_st    <= ST_LOCKED;
                r_lock  <= 1'b1;
                r_retry <= '0;
                r_bad   <= 1'b0;
              end else if (r_retry == RW'(MAX_RETRY - 1)) begin
                r_st    <= ST_FAULT;
                r_fault <= 1'b1;
                r_pwr   <= 1'b0;
                r_retry <= '0;
              end else begin
                r_retry <= r_retry + RW'(1);
              end
            end
          end
          ST_LOCKED: begin
            // A single bad window is tolerated; a second in a row forces a relock.
            if (w_done) begin
              if (w_good) begin
                r_bad <= 1'b0;
              end else if (r_bad) begin
                r_st   <= ST_KICK;
                r_tmr  <= '0;
                r_lock <= 1'b0;
                r_kick <= 1'b1;
                r_bad  <= 1'b0;
              end else begin
                r_bad <= 1'b1;
              end
            end
          end
          ST_FAULT: begin
            r_st <= ST_FAULT;
          end
          default: begin
            r_st    <= ST_OFF;
            r_pwr   <= 1'b0;
            r_kick  <= 1'b0;
            r_lock  <= 1'b0;
            r_fault <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pll_ctrl.md
PLL_CTRL -- requirements
Module: pll_ctrl

Interface
REQ-001 SHALL have parameter PWRUP_CYC, default 8, cycles between PWRUP_1V8 assertion and KICK.
REQ-002 SHALL have parameter KICK_CYC, default 16, cycles KICK is held high.
REQ-003 SHALL have parameter SETTLE_CYC, default 1024, cycles of loop settling after KICK before the first lock measurement.
REQ-004 SHALL have parameter WIN_LOG2, default 6, lock window length is 2^WIN_LOG2 CK_REF cycles.
REQ-005 SHALL have parameter TOL, default 1, allowed absolute error in feedback edge count per window.
REQ-006 SHALL have parameter MAX_RETRY, default 3, failed windows tolerated before FAULT.
REQ-007 SHALL have port CK_REF, input, 1, reference clock; the single clock of the block.
REQ-008 SHALL have port RST_N, input, 1, reset; asynchronous, active-low.
REQ-009 SHALL have port EN, input, 1, PLL enable request, synchronous to CK_REF.
REQ-010 SHALL have port FB_DIV4, input, 1, feedback divider output divided by 4 more; asynchronous to CK_REF; CK_REF/4 when locked.
REQ-011 SHALL have port PWRUP_1V8, output, 1, PLL power-up (drives CP, DIVN, ROSC).
REQ-012 SHALL have port KICK, output, 1, loop-filter kick pulse to the charge pump.
REQ-013 SHALL have port LOCKED, output, 1, lock indication.
REQ-014 SHALL have port FAULT, output, 1, sticky lock failure.
REQ-015 SHALL have port STATE, output, 3, current FSM state encoding, for debug.

Function
REQ-016 SHALL run FSM states OFF, PWRUP, KICK, SETTLE, MEAS, LOCKED, FAULT; all outputs registered.
REQ-017 SHALL move OFF->PWRUP on the first CK_REF edge with EN=1; PWRUP_1V8=1 from that edge in every state except OFF and FAULT.
REQ-018 SHALL stay in PWRUP exactly PWRUP_CYC cycles, then KICK.
REQ-019 SHALL hold KICK=1 exactly KICK_CYC cycles while in KICK; KICK=0 in all other states.
REQ-020 SHALL stay in SETTLE exactly SETTLE_CYC cycles, then MEAS.
REQ-021 SHALL synchronise FB_DIV4 through two flops, then detect rising edges with a third flop; edge count latency is 3 cycles.
REQ-022 SHALL count detected edges over each window of 2^WIN_LOG2 cycles; counter is WIN_LOG2 bits and saturates at all-ones; cleared at window start.
REQ-023 SHALL declare a window good when |count - 2^(WIN_LOG2-2)| <= TOL (16±1 at defaults), evaluated on the window's last cycle.
REQ-024 SHALL in MEAS: good window -> LOCKED, retry counter cleared; bad window -> retry counter +1, stay in MEAS; retry counter reaching MAX_RETRY -> FAULT.
REQ-025 SHALL in LOCKED: keep measuring back-to-back windows; LOCKED=1 only in this state; two consecutive bad windows -> KICK (relock, LOCKED=0 next cycle); one bad window followed by a good one stays LOCKED.
REQ-026 SHALL in FAULT: FAULT=1, PWRUP_1V8=0, KICK=0, remain until EN=0.
REQ-027 SHALL on EN=0 in any state go to OFF on the next edge, all outputs 0, all counters cleared; EN=0 wins over any simultaneous window/timer completion.
REQ-028 SHALL restart the full sequence from PWRUP when EN returns to 1 after OFF; no shortcut to LOCKED.
REQ-029 SHALL treat FB_DIV4 stuck high or low as count 0 (bad window).

Reset
REQ-030 SHALL on RST_N=0 asynchronously force state OFF, PWRUP_1V8=0, KICK=0, LOCKED=0, FAULT=0, STATE=OFF, synchroniser flops and all counters to 0.
REQ-031 SHALL release from reset synchronously; first state change no earlier than the second CK_REF edge after RST_N rises.
REQ-032 SHALL abort any state, including mid-KICK, on reset with KICK falling immediately.

Structure
REQ-033 SHALL place the state enum, STATE encodings (OFF=0 ... FAULT=6) and parameter defaults in shared package pll_ctrl_pkg.
REQ-034 SHALL implement synchroniser, edge detector, window timer and comparator as sub-module pll_ctrl_lockdet producing a one-cycle WIN_DONE and WIN_GOOD.

Verification
REQ-035 SHALL verify nominal lock: EN=1, FB_DIV4=CK_REF/4 -> PWRUP_1V8 at cycle 1, KICK cycles 9-24, LOCKED rising after first window (cycle ~1113).
REQ-036 SHALL verify tolerance edges: FB_DIV4 giving 15 and 17 edges per window -> LOCKED; 14 or 18 -> not locked.
REQ-037 SHALL verify fault: FB_DIV4 held 0 -> three bad windows -> FAULT=1, PWRUP_1V8=0; EN=0 then 1 -> restart at PWRUP.
REQ-038 SHALL verify loss of lock: in LOCKED, FB_DIV4 frequency halved for two windows -> LOCKED=0, KICK pulse of 16 cycles, relock after recovery.
REQ-039 SHALL verify EN=0 on same cycle as window end in MEAS -> OFF, LOCKED stays 0.
REQ-040 SHALL verify RST_N pulsed low mid-KICK -> KICK and PWRUP_1V8 drop without waiting for a CK_REF edge, STATE=0.
